// File: rtl/bitwise_logic_seq.sv
// Sliced bitwise logic unit: applies one of eight logic functions to two operands,
// SLICE bits per clock, and reports zero/parity flags of the completed result.
module bitwise_logic_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned IDXW   = $clog2(NSLICE) + 1;

    if (WIDTH < 1 || SLICE < 1) begin : g_bad_size
        $error("bitwise_logic_seq: WIDTH and SLICE must both be at least 1");
    end
    if (SLICE != 0 && (WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("bitwise_logic_seq: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  y_q;
    logic              acc_q;
    logic              zero_q;
    logic              parity_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [31:0]       base;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  res_sl;
    logic [WIDTH-1:0]  slice_mask;
    logic [WIDTH-1:0]  y_next;
    logic              acc_next;
    logic              last_slice;

    // Shift-based slicing keeps the variable select free of width truncation.
    always_comb begin
        base       = 32'(idx_q) * SLICE;
        a_sl       = SLICE'(a_q >> base);
        b_sl       = SLICE'(b_q >> base);
        slice_mask = WIDTH'({SLICE{1'b1}}) << base;
        last_slice = (idx_q == IDXW'(NSLICE - 1));
    end

    always_comb begin
        res_sl = '0;
        unique case (op_q)
            3'b000: res_sl = a_sl & b_sl;
            3'b001: res_sl = a_sl | b_sl;
            3'b010: res_sl = a_sl ^ b_sl;
            3'b011: res_sl = ~(a_sl | b_sl);
            3'b100: res_sl = ~(a_sl ^ b_sl);
            3'b101: res_sl = ~(a_sl & b_sl);
            3'b110: res_sl = a_sl & ~b_sl;
            3'b111: res_sl = a_sl;
            default: res_sl = '0;
        endcase
    end

    always_comb begin
        y_next   = (y_q & ~slice_mask) | (WIDTH'(res_sl) << base);
        acc_next = acc_q ^ (^res_sl);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            y_q         <= '0;
            acc_q       <= 1'b0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        op_q       <= op;
                        idx_q      <= '0;
                        y_q        <= '0;
                        acc_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    y_q   <= y_next;
                    acc_q <= acc_next;
                    if (last_slice) begin
                        zero_q      <= (y_next == '0);
                        parity_q    <= acc_next;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Scoreboard bench for bitwise_logic_seq at three parameter points: 32/8, 16/16 and 32/4.
module tb_bitwise_logic_seq;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   sweep_on = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t m0_e, m1_e, m2_e;

    // DUT0: WIDTH=32, SLICE=8
    logic        in_valid0, in_ready0, out_valid0, out_ready0, zero0, parity0;
    logic [2:0]  op0;
    logic [31:0] a0, b0, y0;
    // DUT1: WIDTH=16, SLICE=16
    logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, parity1;
    logic [2:0]  op1;
    logic [15:0] a1, b1, y1;
    // DUT2: WIDTH=32, SLICE=4
    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, parity2;
    logic [2:0]  op2;
    logic [31:0] a2, b2, y2;

    always #5 clk = ~clk;

    bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .op(op0), .out_valid(out_valid0), .out_ready(out_ready0),
        .y(y0), .zero(zero0), .parity(parity0)
    );
    bitwise_logic_seq #(.WIDTH(16), .SLICE(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .zero(zero1), .parity(parity1)
    );
    bitwise_logic_seq #(.WIDTH(32), .SLICE(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .zero(zero2), .parity(parity2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] z);
        case (f)
            3'd0: model = x & z;
            3'd1: model = x | z;
            3'd2: model = x ^ z;
            3'd3: model = ~(x | z);
            3'd4: model = ~(x ^ z);
            3'd5: model = ~(x & z);
            3'd6: model = x & ~z;
            default: model = x;
        endcase
    endfunction

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected result: got y=%h, expected no output", y0);
            end else begin
                m0_e = q0.pop_front();
                check("dut0 y", y0, m0_e.y);
                check("dut0 zero", 32'(zero0), 32'(m0_e.z));
                check("dut0 parity", 32'(parity0), 32'(m0_e.p));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected result: got y=%h, expected no output", y1);
            end else begin
                m1_e = q1.pop_front();
                check("dut1 y", {16'h0, y1}, m1_e.y);
                check("dut1 zero", 32'(zero1), 32'(m1_e.z));
                check("dut1 parity", 32'(parity1), 32'(m1_e.p));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2 unexpected result: got y=%h, expected no output", y2);
            end else begin
                m2_e = q2.pop_front();
                check("dut2 y", y2, m2_e.y);
                check("dut2 zero", 32'(zero2), 32'(m2_e.z));
                check("dut2 parity", 32'(parity2), 32'(m2_e.p));
            end
        end
    end

    // Issue one DUT0 operation from idle (called at posedge+1) and track latency/handshake.
    task automatic run0(input string name, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] z, input logic [31:0] ey, input logic ez,
                        input logic ep);
        exp_t e;
        int   n;
        check({name, " in_ready before"}, 32'(in_ready0), 32'd1);
        e.y = ey; e.z = ez; e.p = ep;
        q0.push_back(e);
        op0 = f; a0 = x; b0 = z; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd4);
        if (out_ready0) begin
            @(posedge clk); #1;
            check({name, " out_valid after handshake"}, 32'(out_valid0), 32'd0);
            check({name, " in_ready after handshake"}, 32'(in_ready0), 32'd1);
        end
    endtask

    task automatic run1(input string name, input logic [2:0] f, input logic [15:0] x,
                        input logic [15:0] z, input logic [31:0] ey, input logic ez,
                        input logic ep);
        exp_t e;
        int   n;
        e.y = ey; e.z = ez; e.p = ep;
        q1.push_back(e);
        op1 = f; a1 = x; b1 = z; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd1);
        @(posedge clk); #1;
        check({name, " in_ready after handshake"}, 32'(in_ready1), 32'd1);
    endtask

    // Random out_ready stalls on DUT2 during the sweep.
    initial begin
        out_ready2 = 1'b1;
        wait (sweep_on);
        while (sweep_on) begin
            @(posedge clk); #1;
            out_ready2 = ($urandom_range(0, 2) != 0);
        end
        out_ready2 = 1'b1;
    end

    initial begin
        #600000;
        $display("FAIL global timeout: got no finish, expected finish before 600000");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        exp_t e;
        rst_n = 1'b0;
        in_valid0 = 0; out_ready0 = 1; op0 = 0; a0 = 0; b0 = 0;
        in_valid1 = 0; out_ready1 = 1; op1 = 0; a1 = 0; b1 = 0;
        in_valid2 = 0;                 op2 = 0; a2 = 0; b2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid0), 32'd0);
        check("reset y", y0, 32'd0);
        check("reset zero", 32'(zero0), 32'd0);
        check("reset parity", 32'(parity0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 32'(in_ready0), 32'd1);

        run0("xor", 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0);
        run0("xnor", 3'b100, 32'h00000001, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b1);
        run0("andn", 3'b110, 32'hFF00FF00, 32'hF000F000, 32'h0F000F00, 1'b0, 1'b0);

        // Backpressure: hold the result while inputs churn.
        out_ready0 = 1'b0;
        run0("or", 3'b001, 32'h0000FFFF, 32'h00FF0000, 32'h00FFFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a0 = $urandom; b0 = $urandom; op0 = 3'(k); in_valid0 = k[0];
            @(posedge clk); #1;
            check("stall out_valid", 32'(out_valid0), 32'd1);
            check("stall y", y0, 32'h00FFFFFF);
            check("stall in_ready", 32'(in_ready0), 32'd0);
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        check("stall release out_valid", 32'(out_valid0), 32'd0);
        check("stall release in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;
        check("no accept while stalled", 32'(in_ready0), 32'd1);

        run0("and", 3'b000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0);

        // Reset in the middle of a NAND (all-ones result, two slices written).
        op0 = 3'b101; a0 = 32'h0; b0 = 32'h0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun reset out_valid", 32'(out_valid0), 32'd0);
        check("midrun reset y", y0, 32'd0);
        check("midrun reset zero", 32'(zero0), 32'd0);
        check("midrun reset parity", 32'(parity0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrun reset in_ready", 32'(in_ready0), 32'd1);
        run0("xor after reset", 3'b010, 32'h0000000F, 32'h00000001, 32'h0000000E, 1'b0, 1'b1);

        run1("w16 passa", 3'b111, 16'h8001, 16'h1234, 32'h00008001, 1'b0, 1'b0);
        run1("w16 nor", 3'b011, 16'h00FF, 16'h0F00, 32'h0000F000, 1'b0, 1'b0);
        run1("w16 xnor", 3'b100, 16'hAAAA, 16'h5555, 32'h00000000, 1'b1, 1'b0);

        // Random sweep on DUT2 against the model.
        sweep_on = 1;
        for (int i = 0; i < 200; i++) begin
            n = 0;
            while (!in_ready2 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready2) begin
                check("dut2 in_ready wait", 32'(in_ready2), 32'd1);
                break;
            end
            op2 = 3'($urandom_range(0, 7));
            a2 = $urandom;
            b2 = $urandom;
            e.y = model(op2, a2, b2);
            e.z = (e.y == 32'd0);
            e.p = ^e.y;
            q2.push_back(e);
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
        end
        n = 0;
        while (q2.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        sweep_on = 0;
        repeat (2) @(posedge clk);
        #1;
        check("dut0 queue drained", 32'(q0.size()), 32'd0);
        check("dut1 queue drained", 32'(q1.size()), 32'd0);
        check("dut2 queue drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
